dmem_bridge: RTL and testbench



---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_bridge.sv | 112 +++++++++++
 tb/tb_dmem_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the M-stage data-bus bridge
package dmem_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } dmem_state_e;

  // Byte-strobe width for the default 32-bit data bus
  localparam int DMEM_STRB_W = 4;

  // Word returned to the M stage when a transaction is abandoned by the watchdog
  localparam logic [31:0] DMEM_TMO_RDATA = 32'h0;

endpackage

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage request/response data-bus bridge; optional watchdog under DMEM_TIMEOUT_EN
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memenM,
  input  logic [ADDR_W-1:0]   aluoutM,
  input  logic [DATA_W-1:0]   writedataM,
  input  logic [DATA_W/8-1:0] waM,
  output logic [DATA_W-1:0]   readdataM,
  output logic                stallM,
  output logic                errM,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  dmem_state_e         state_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [DATA_W/8-1:0] req_wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                xfer_done;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             err_q;
  assign errM = err_q;
`else
  assign errM = 1'b0;
`endif

  // Response completes the transaction: data_ok with addr_ok in ADDR, or data_ok in DATA
  assign xfer_done = ((state_q == ADDR) && bus_addr_ok && bus_data_ok) ||
                     ((state_q == DATA) && bus_data_ok);

  // Stall from the moment an access appears in IDLE until the DONE cycle releases the pipe
  assign stallM = (state_q == IDLE) ? memenM : (state_q != DONE);

  assign bus_req   = (state_q == ADDR);
  assign bus_addr  = req_addr_q;
  assign bus_wdata = req_wdata_q;
  assign bus_wstrb = req_wstrb_q;
  assign bus_wr    = |req_wstrb_q;
  assign readdataM = rdata_q;

  // Transaction FSM with request registers, read capture and optional watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rdata_q     <= '0;
`ifdef DMEM_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef DMEM_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (memenM) begin
            // Word-align here so the bus never sees the byte offset
            req_addr_q  <= aluoutM & ~ADDR_W'(3);
            req_wdata_q <= writedataM;
            req_wstrb_q <= waM;
            state_q     <= ADDR;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
          end
        end
        ADDR, DATA: begin
          if (xfer_done) begin
            state_q <= DONE;
            if (~|req_wstrb_q) rdata_q <= bus_rdata;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= DONE;
            rdata_q <= DATA_W'(DMEM_TMO_RDATA);
            err_q   <= 1'b1;
          end
`endif
          else if ((state_q == ADDR) && bus_addr_ok) begin
            state_q <= DATA;
          end
`ifdef DMEM_TIMEOUT_EN
          tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
`endif
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [3:0]  waM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        errM;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int tests  = 0;
  int failed = 0;

  int          stall_n;
  int          req_n;
  logic [31:0] cap_addr;
  logic        cap_wr;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_wdata;

  always #5 clk = ~clk;

  dmem_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memenM(memenM),
    .aluoutM(aluoutM),
    .writedataM(writedataM),
    .waM(waM),
    .readdataM(readdataM),
    .stallM(stallM),
    .errM(errM),
    .bus_req(bus_req),
    .bus_wr(bus_wr),
    .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One access: aw ADDR cycles before addr_ok, dw DATA cycles up to and including data_ok
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wa,
                         input int aw, input int dw, input logic [31:0] rd, input bit from_done);
    int k = 0;
    int j = 0;
    bit acc = 1'b0;
    memenM = 1'b1; aluoutM = addr; writedataM = wdata; waM = wa;
    bus_rdata = rd; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    stall_n = 0; req_n = 0;
    #1;
    if (from_done) begin
      chk("done_stall", {31'd0, stallM}, 32'd0);
      chk("done_noreq", {31'd0, bus_req}, 32'd0);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      if (!stallM) break;
      stall_n++;
      if (i == 0) chk("idle_noreq", {31'd0, bus_req}, 32'd0);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (bus_req) begin
        if (k == 0) begin
          cap_addr = bus_addr; cap_wr = bus_wr; cap_wstrb = bus_wstrb; cap_wdata = bus_wdata;
        end
        req_n++;
        if (k == aw) begin
          bus_addr_ok = 1'b1;
          bus_data_ok = (dw == 0);
          acc = 1'b1;
        end
        k++;
      end else if (acc) begin
        j++;
        bus_data_ok = (j == dw);
      end
      tick();
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    memenM = 1'b0;
    chk("txn_bound", {31'd0, stallM}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; memenM = 1'b0; aluoutM = '0; writedataM = '0; waM = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_rdata", readdataM, 32'd0);
    chk("rst_err", {31'd0, errM}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);

    // Load, zero-wait
    run_txn(32'h0000_0104, 32'h0, 4'b0000, 0, 0, 32'h1234_5678, 1'b0);
    chk("ld0_stall", stall_n, 2);
    chk("ld0_req", req_n, 1);
    chk("ld0_addr", cap_addr, 32'h104);
    chk("ld0_wr", {31'd0, cap_wr}, 32'd0);
    chk("ld0_rdata", readdataM, 32'h1234_5678);
    chk("ld0_err", {31'd0, errM}, 32'd0);
    tick();
    chk("ld0_idle", {30'd0, bus_req, stallM}, 32'd0);

    // Byte store with waits
    run_txn(32'h0000_0200, 32'h00AB_0000, 4'b0100, 3, 2, 32'hDEAD_BEEF, 1'b0);
    chk("st_stall", stall_n, 7);
    chk("st_req", req_n, 4);
    chk("st_wstrb", {28'd0, cap_wstrb}, 32'h4);
    chk("st_wr", {31'd0, cap_wr}, 32'd1);
    chk("st_wdata", cap_wdata, 32'h00AB_0000);
    chk("st_rdata_keep", readdataM, 32'h1234_5678);
    tick();

    // Back-to-back load then store, unaligned load address
    run_txn(32'h0000_0013, 32'h0, 4'b0000, 1, 1, 32'hCAFE_F00D, 1'b0);
    chk("b2b_ld_stall", stall_n, 4);
    chk("b2b_ld_req", req_n, 2);
    chk("b2b_ld_addr", cap_addr, 32'h10);
    chk("b2b_ld_rdata", readdataM, 32'hCAFE_F00D);
    run_txn(32'h0000_0014, 32'h1122_3344, 4'b1111, 0, 1, 32'h0, 1'b1);
    chk("b2b_st_stall", stall_n, 3);
    chk("b2b_st_req", req_n, 1);
    chk("b2b_st_addr", cap_addr, 32'h14);
    chk("b2b_st_wr", {31'd0, cap_wr}, 32'd1);
    chk("b2b_st_rdata", readdataM, 32'hCAFE_F00D);
    tick();

    // Reset while in DATA
    memenM = 1'b1; aluoutM = 32'h40; waM = 4'b0000; bus_rdata = 32'h0BAD_0BAD;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    #1;
    chk("rdat_req", {31'd0, bus_req}, 32'd0);
    chk("rdat_stall", {31'd0, stallM}, 32'd1);
    rst = 1'b1;
    tick();
    #1;
    chk("rmid_req", {31'd0, bus_req}, 32'd0);
    chk("rmid_rdata", readdataM, 32'd0);
    chk("rmid_stall", {31'd0, stallM}, 32'd1);
    rst = 1'b0; memenM = 1'b0; bus_data_ok = 1'b1;
    #1;
    chk("rmid_stall_off", {31'd0, stallM}, 32'd0);
    tick();
    bus_data_ok = 1'b0;
    #1;
    chk("late_rdata", readdataM, 32'd0);
    chk("late_idle", {30'd0, bus_req, stallM}, 32'd0);
    tick();
    chk("late_idle2", {30'd0, bus_req, stallM}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // Watchdog: no addr_ok ever
    run_txn(32'h20, 32'h0, 4'b0000, 0, 0, 32'h55AA_55AA, 1'b0);
    chk("pre_tmo_rdata", readdataM, 32'h55AA_55AA);
    tick();
    run_txn(32'h24, 32'h0, 4'b0000, 1000, 0, 32'h77, 1'b0);
    chk("tmo_stall", stall_n, 9);
    chk("tmo_req", req_n, 8);
    chk("tmo_err", {31'd0, errM}, 32'd1);
    chk("tmo_rdata", readdataM, 32'd0);
    tick();
    chk("tmo_err_clr", {31'd0, errM}, 32'd0);
    chk("tmo_idle", {30'd0, bus_req, stallM}, 32'd0);
`endif

    // No access for 20 cycles
    for (int i = 0; i < 20; i++) begin
      chk("quiet", {29'd0, errM, bus_req, stallM}, 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
